// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
// The top level re-declares the entry layout locally so that INDEX_WIDTH overrides stay consistent.
package branch_pkg;

  localparam int unsigned BQ_INDEX_WIDTH = 8;
  localparam logic [31:0] BQ_PC_STEP     = 32'd4;

  typedef struct packed {
    logic [31:0]               pc;
    logic [BQ_INDEX_WIDTH-1:0] index;
    logic                      pred;
  } bq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_bq_fifo.sv
// DEPTH-entry circular buffer with push/pop/clear; clear wins over push and pop.
// Storage is deliberately left unreset; only pointers and the occupancy count reset.
module bq_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign rdata   = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + PW'(1);
      if (pop_ok)  rp <= rp + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Resolution side of the gshare predictor: in-order branch queue, predictor update strobe,
// and mispredict redirect with queue flush. Update pulses are always separated by an idle cycle.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = BQ_INDEX_WIDTH,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [31:0]            push_pc,
  input  logic [INDEX_WIDTH-1:0] push_index,
  input  logic                   push_pred,
  output logic                   full,
  input  logic                   resolve,
  input  logic                   resolve_taken,
  input  logic [31:0]            resolve_target,
  output logic                   resolve_ready,
  input  logic                   flush,
  output logic                   upd_valid,
  output logic [INDEX_WIDTH-1:0] upd_index,
  output logic                   upd_taken,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc
);

  typedef struct packed {
    logic [31:0]            pc;
    logic [INDEX_WIDTH-1:0] index;
    logic                   pred;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  entry_t wentry;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   res_acc;
  logic   mispredict_now;
  logic   push_acc;
  logic   pop;
  logic   clear;

  assign wentry = '{pc: push_pc, index: push_index, pred: push_pred};

  assign full          = fifo_full;
  assign resolve_ready = !fifo_empty && !upd_valid;

  // A mispredict squashes the whole queue, including anything fetched alongside it.
  assign res_acc        = resolve && resolve_ready && !flush;
  assign mispredict_now = res_acc && (resolve_taken != head.pred);
  assign push_acc       = push && !fifo_full && !flush && !mispredict_now;
  assign pop            = res_acc && !mispredict_now;
  assign clear          = flush || mispredict_now;

  bq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (pop),
    .clear (clear),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid      <= 1'b0;
      upd_index      <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      upd_valid      <= res_acc;
      upd_index      <= res_acc ? head.index : '0;
      upd_taken      <= res_acc ? resolve_taken : 1'b0;
      redirect_valid <= mispredict_now;
      if (mispredict_now)
        redirect_pc <= resolve_taken ? resolve_target : head.pc + BQ_PC_STEP;
      else
        redirect_pc <= '0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench: stimulus pushes expected update/redirect events into a scoreboard queue,
// a negedge monitor pops and compares whenever the DUT emits an update or redirect.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [31:0] push_pc = '0;
  logic [7:0]  push_index = '0;
  logic        push_pred = 1'b0;
  logic        full;
  logic        resolve = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        resolve_ready;
  logic        flush = 1'b0;
  logic        upd_valid;
  logic [7:0]  upd_index;
  logic        upd_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [7:0]  idx;
    logic        taken;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned upd_pulses = 0;
  logic        prev_upd = 1'b0;

  branch_resolve_queue #(
    .INDEX_WIDTH (8),
    .DEPTH       (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_pc        (push_pc),
    .push_index     (push_index),
    .push_pred      (push_pred),
    .full           (full),
    .resolve        (resolve),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .resolve_ready  (resolve_ready),
    .flush          (flush),
    .upd_valid      (upd_valid),
    .upd_index      (upd_index),
    .upd_taken      (upd_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: every emitted update/redirect must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (upd_valid) begin
        upd_pulses++;
        check("upd pulse gap", {31'd0, prev_upd}, 32'd0);
      end
      if (upd_valid || redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("upd_valid", {31'd0, upd_valid}, 32'd1);
          check("upd_index", {24'd0, upd_index}, {24'd0, e.idx});
          check("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
          check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.redir});
          if (e.redir) check("redirect_pc", redirect_pc, e.rpc);
        end
      end
      prev_upd = upd_valid;
    end else begin
      prev_upd = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic [7:0] idx, input logic pr);
    push = 1'b1; push_pc = pc; push_index = idx; push_pred = pr;
    step();
    push = 1'b0;
  endtask

  task automatic do_resolve(input logic tk, input logic [31:0] tgt, input bit expect_out,
                            input logic [7:0] eidx, input logic eredir, input logic [31:0] erpc);
    check("resolve_ready before resolve", {31'd0, resolve_ready}, 32'd1);
    if (expect_out) exp_q.push_back('{eidx, tk, eredir, erpc});
    resolve = 1'b1; resolve_taken = tk; resolve_target = tgt;
    step();
    resolve = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    bit         pat [7];
    logic [7:0] k;
    int unsigned start;

    // Reset state
    #2;
    check("reset upd_valid", {31'd0, upd_valid}, 32'd0);
    check("reset full", {31'd0, full}, 32'd0);
    check("reset resolve_ready", {31'd0, resolve_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset mid-stream with count=3 and upd_valid=1
    for (int i = 0; i < 4; i++) do_push(32'h1000 + 32'(i) * 4, 8'h01 + 8'(i), 1'b0);
    check("t1 full", {31'd0, full}, 32'd1);
    do_resolve(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0);
    check("t1 upd_valid before rst", {31'd0, upd_valid}, 32'd1);
    check("t1 upd_index before rst", {24'd0, upd_index}, 32'h01);
    rst = 1'b1;
    #1;
    check("t1 rst upd_valid", {31'd0, upd_valid}, 32'd0);
    check("t1 rst upd_index", {24'd0, upd_index}, 32'd0);
    check("t1 rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("t1 rst full", {31'd0, full}, 32'd0);
    check("t1 rst resolve_ready", {31'd0, resolve_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: correct taken prediction
    do_push(32'h100, 8'h5A, 1'b1);
    do_resolve(1'b1, 32'h800, 1'b1, 8'h5A, 1'b0, 32'h0);
    step();
    check("t2 ready empty", {31'd0, resolve_ready}, 32'd0);

    // 3: mispredict, fallthrough redirect; same-cycle push is wrong-path
    do_push(32'h200, 8'h33, 1'b1);
    push = 1'b1; push_pc = 32'h300; push_index = 8'h77; push_pred = 1'b0;
    do_resolve(1'b0, 32'h999, 1'b1, 8'h33, 1'b1, 32'h204);
    push = 1'b0;
    step();
    check("t3 ready after flush", {31'd0, resolve_ready}, 32'd0);
    check("t3 full", {31'd0, full}, 32'd0);
    do_push(32'h400, 8'h21, 1'b1);
    do_resolve(1'b1, 32'h480, 1'b1, 8'h21, 1'b0, 32'h0);
    step();

    // 4: fill, drop 5th push, drain in order with pointer wrap
    for (int i = 0; i < 4; i++) do_push(32'h1000 + 32'(i) * 4, 8'h10 + 8'(i), 1'b0);
    check("t4 full", {31'd0, full}, 32'd1);
    do_push(32'h2000, 8'h99, 1'b0);
    check("t4 full after drop", {31'd0, full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_resolve(1'b0, 32'h0, 1'b1, 8'h10 + 8'(i), 1'b0, 32'h0);
      check("t4 ready during upd", {31'd0, resolve_ready}, 32'd0);
      step();
    end
    check("t4 ready empty", {31'd0, resolve_ready}, 32'd0);
    check("t4 not full", {31'd0, full}, 32'd0);
    do_push(32'h3000, 8'h20, 1'b0);
    do_resolve(1'b1, 32'h4440, 1'b1, 8'h20, 1'b1, 32'h4440);
    step();
    do_push(32'hFFFF_FFFC, 8'h2F, 1'b1);
    do_resolve(1'b0, 32'h0, 1'b1, 8'h2F, 1'b1, 32'h0);
    step();

    // 5: resolve held high against 3 correct entries
    for (int i = 0; i < 3; i++) do_push(32'h500 + 32'(i) * 4, 8'h40 + 8'(i), 1'b1);
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    k = 8'h40;
    start = upd_pulses;
    resolve = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h5000;
    for (int i = 0; i < 7; i++) begin
      check("t5 resolve_ready", {31'd0, resolve_ready}, {31'd0, pat[i]});
      if (pat[i]) begin
        exp_q.push_back('{k, 1'b1, 1'b0, 32'h0});
        k = k + 8'd1;
      end
      step();
    end
    resolve = 1'b0;
    step();
    check("t5 upd pulse count", upd_pulses - start, 32'd3);

    // 6: flush right after an accepted resolve
    do_push(32'h600, 8'h50, 1'b0);
    do_push(32'h604, 8'h51, 1'b0);
    do_resolve(1'b0, 32'h0, 1'b1, 8'h50, 1'b0, 32'h0);
    flush = 1'b1;
    push = 1'b1; push_pc = 32'h700; push_index = 8'h66; push_pred = 1'b0;
    step();
    flush = 1'b0; push = 1'b0;
    check("t6 ready after flush", {31'd0, resolve_ready}, 32'd0);
    check("t6 full after flush", {31'd0, full}, 32'd0);
    step();
    check("t6 ready still empty", {31'd0, resolve_ready}, 32'd0);

    // flush blocks a same-cycle resolve: no update may appear
    do_push(32'h800, 8'h70, 1'b1);
    check("flush-block ready", {31'd0, resolve_ready}, 32'd1);
    resolve = 1'b1; resolve_taken = 1'b1; flush = 1'b1;
    step();
    resolve = 1'b0; flush = 1'b0;
    step();
    check("flush-block ready empty", {31'd0, resolve_ready}, 32'd0);

    step();
    step();
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
